// File: rtl/memory_pkg.sv
// Shared memory-access constants: line geometry and the read/write split FSM encodings.
package memory_pkg;

  localparam int MEM_LINE_LOG2 = 4;

  typedef enum logic [1:0] {
    RD_IDLE       = 2'd0,
    RD_FIRST_WAIT = 2'd1,
    RD_SECOND     = 2'd2
  } read_state_t;

  typedef enum logic [1:0] {
    WR_IDLE       = 2'd0,
    WR_FIRST_WAIT = 2'd1,
    WR_SECOND     = 2'd2
  } write_state_t;

  // Bytes that fit before the line boundary: min(len, left), left is 1..line size.
  function automatic logic [2:0] min_len(input logic [2:0] len, input logic [31:0] left);
    return ({29'd0, len} < left) ? len : left[2:0];
  endfunction

endpackage

// File: rtl/memory_read_merge.sv
// Byte merge for a split read: keeps the low bytes of the first half and ORs in the shifted second half.
module memory_read_merge (
  input  logic [31:0] tlbread_data,
  input  logic [2:0]  length_1,
  input  logic [23:0] buffer,
  output logic [23:0] buffer_next,
  output logic [31:0] merged
);

  always_comb begin
    buffer_next = '0;
    for (int i = 0; i < 3; i++) begin
      if (3'(i) < length_1) buffer_next[8*i +: 8] = tlbread_data[8*i +: 8];
    end
    merged = {8'd0, buffer} | (tlbread_data << {length_1, 3'b000});
  end

endmodule

// File: rtl/memory_read_split.sv
// Read front end: issues one TLB access per read, or two when a read crosses a line boundary.
// Line splitting is built only when MEMORY_READ_SPLIT_EN is defined; otherwise reads pass through whole.
import memory_pkg::*;

module memory_read_split #(
  parameter int LINE_LOG2 = MEM_LINE_LOG2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rd_reset,
  input  logic        read_do,
  output logic        read_done,
  output logic        read_page_fault,
  output logic        read_ac_fault,
  input  logic [1:0]  read_cpl,
  input  logic [31:0] read_address,
  input  logic [2:0]  read_length,
  input  logic        read_lock,
  input  logic        read_rmw,
  output logic [31:0] read_data,
  output logic        tlbread_do,
  input  logic        tlbread_done,
  input  logic        tlbread_page_fault,
  input  logic        tlbread_ac_fault,
  output logic [1:0]  tlbread_cpl,
  output logic [31:0] tlbread_address,
  output logic [2:0]  tlbread_length,
  output logic [2:0]  tlbread_length_full,
  output logic        tlbread_lock,
  output logic        tlbread_rmw,
  input  logic [31:0] tlbread_data,
  output logic [1:0]  debug_state
);

  // A 4-byte read must cross at most one boundary, so lines are at least 4 bytes.
  if (LINE_LOG2 < 2 || LINE_LOG2 > 31) begin : g_bad_line
    $error("memory_read_split: LINE_LOG2 out of range");
  end

  read_state_t state;
  logic [2:0]  length_1;
  logic [2:0]  len2_q;
  logic [31:0] addr2_q;
  logic [31:0] second_data;
  logic        start;
  logic        any_fault;
  logic        reset_waiting;
  logic        sticky_pf;
  logic        sticky_ac;

  assign tlbread_cpl         = read_cpl;
  assign tlbread_length_full = read_length;
  assign tlbread_lock        = read_lock;
  assign tlbread_rmw         = read_rmw;
  assign debug_state         = state;

  assign read_page_fault = tlbread_page_fault | sticky_pf;
  assign read_ac_fault   = tlbread_ac_fault | sticky_ac;
  assign any_fault       = tlbread_page_fault | tlbread_ac_fault;
  assign start = (state == RD_IDLE) && read_do && !rd_reset && !read_page_fault && !read_ac_fault;

`ifdef MEMORY_READ_SPLIT_EN
  logic [31:0] line_bytes;
  logic [31:0] offset;
  logic [31:0] left;
  logic [2:0]  length_2;
  logic [31:0] address_2;
  logic [2:0]  len1_q;
  logic [23:0] buffer;
  logic [23:0] buffer_next;

  assign line_bytes = 32'd1 << LINE_LOG2;
  assign offset     = read_address & (line_bytes - 32'd1);
  assign left       = line_bytes - offset;
  assign length_1   = min_len(read_length, left);
  assign length_2   = read_length - length_1;
  assign address_2  = (read_address & ~(line_bytes - 32'd1)) + line_bytes;

  memory_read_merge u_merge (
    .tlbread_data (tlbread_data),
    .length_1     (len1_q),
    .buffer       (buffer),
    .buffer_next  (buffer_next),
    .merged       (second_data)
  );

  // Second-half geometry is frozen at issue so the CPU side may change meanwhile.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len1_q  <= '0;
      len2_q  <= '0;
      addr2_q <= '0;
      buffer  <= '0;
    end else begin
      if (start) begin
        len1_q  <= length_1;
        len2_q  <= length_2;
        addr2_q <= address_2;
      end
      if (state == RD_FIRST_WAIT && tlbread_done && !any_fault && len2_q != 3'd0)
        buffer <= buffer_next;
    end
  end
`else
  assign length_1    = read_length;
  assign len2_q      = 3'd0;
  assign addr2_q     = 32'd0;
  assign second_data = tlbread_data;
`endif

  always_comb begin
    tlbread_do      = 1'b0;
    tlbread_address = read_address;
    tlbread_length  = length_1;
    read_done       = 1'b0;
    read_data       = '0;
    case (state)
      RD_IDLE: tlbread_do = start;
      RD_FIRST_WAIT: begin
        tlbread_do = 1'b1;
        if (tlbread_done && !any_fault && len2_q == 3'd0 && !reset_waiting) begin
          read_done = 1'b1;
          read_data = tlbread_data;
        end
      end
      RD_SECOND: begin
        tlbread_do      = 1'b1;
        tlbread_address = addr2_q;
        tlbread_length  = len2_q;
        if (tlbread_done && !any_fault && !reset_waiting) begin
          read_done = 1'b1;
          read_data = second_data;
        end
      end
      default: tlbread_do = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= RD_IDLE;
      reset_waiting <= 1'b0;
      sticky_pf     <= 1'b0;
      sticky_ac     <= 1'b0;
    end else begin
      // An aborted access still runs to completion; its result is just dropped.
      if (rd_reset && state != RD_IDLE) reset_waiting <= 1'b1;
      else if (state == RD_IDLE)        reset_waiting <= 1'b0;

      if (rd_reset)                                    sticky_pf <= 1'b0;
      else if (tlbread_page_fault && !reset_waiting)   sticky_pf <= 1'b1;
      if (rd_reset)                                    sticky_ac <= 1'b0;
      else if (tlbread_ac_fault && !reset_waiting)     sticky_ac <= 1'b1;

      case (state)
        RD_IDLE: if (start) state <= RD_FIRST_WAIT;
        RD_FIRST_WAIT: begin
          if (any_fault)                 state <= RD_IDLE;
          else if (tlbread_done)         state <= (len2_q != 3'd0) ? RD_SECOND : RD_IDLE;
        end
        RD_SECOND: if (any_fault || tlbread_done) state <= RD_IDLE;
        default: state <= RD_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_read_split.sv
// Bench for memory_read_split: CPU-side driver plus TLB responder backed by a byte memory model,
// with a scoreboard monitor comparing every read_done against the queued expected data.
module tb_memory_read_split;
  import memory_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rd_reset = 1'b0;
  logic        read_do = 1'b0;
  logic        read_done, read_page_fault, read_ac_fault;
  logic [1:0]  read_cpl = '0;
  logic [31:0] read_address = '0;
  logic [2:0]  read_length = 3'd1;
  logic        read_lock = 1'b0, read_rmw = 1'b0;
  logic [31:0] read_data;
  logic        tlbread_do;
  logic        tlbread_done = 1'b0, tlbread_page_fault = 1'b0, tlbread_ac_fault = 1'b0;
  logic [1:0]  tlbread_cpl;
  logic [31:0] tlbread_address;
  logic [2:0]  tlbread_length, tlbread_length_full;
  logic        tlbread_lock, tlbread_rmw;
  logic [31:0] tlbread_data = '0;
  logic [1:0]  debug_state;

  always #5 clk = ~clk;

  memory_read_split #(.LINE_LOG2(4)) dut (
    .clk(clk), .rst_n(rst_n), .rd_reset(rd_reset),
    .read_do(read_do), .read_done(read_done),
    .read_page_fault(read_page_fault), .read_ac_fault(read_ac_fault),
    .read_cpl(read_cpl), .read_address(read_address), .read_length(read_length),
    .read_lock(read_lock), .read_rmw(read_rmw), .read_data(read_data),
    .tlbread_do(tlbread_do), .tlbread_done(tlbread_done),
    .tlbread_page_fault(tlbread_page_fault), .tlbread_ac_fault(tlbread_ac_fault),
    .tlbread_cpl(tlbread_cpl), .tlbread_address(tlbread_address),
    .tlbread_length(tlbread_length), .tlbread_length_full(tlbread_length_full),
    .tlbread_lock(tlbread_lock), .tlbread_rmw(tlbread_rmw),
    .tlbread_data(tlbread_data), .debug_state(debug_state)
  );

  int tests_run = 0;
  int tests_failed = 0;
  logic [31:0] exp_q[$];
  logic [7:0]  mem[int unsigned];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] byte_at(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a[7:0] ^ a[15:8] ^ {a[3:0], a[19:16]} ^ 8'h5a;
  endfunction

  function automatic logic [31:0] bytes_le(input logic [31:0] a, input int n);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < n; i++) r[8*i +: 8] = byte_at(a + 32'(i));
    return r;
  endfunction

  // Scoreboard monitor
  initial begin
    forever begin
      @(negedge clk); #2;
      if (read_done) begin
        if (exp_q.size() == 0) begin
          tests_run++; tests_failed++;
          $display("FAIL unexpected_done: got read_data %h, expected no read_done", read_data);
        end else check("read_data", read_data, exp_q.pop_front());
      end else check("data_when_idle", read_data, 32'd0);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected bench completion");
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
    $fatal(1, "watchdog");
  end

  // fault_at: 0 none, k = fault on access k. mid_reset pulses rd_reset during the first wait.
  task automatic do_read(input logic [31:0] addr, input logic [2:0] len, input int fault_at,
                         input bit fault_pf, input bit mid_reset, input bit use_lit,
                         input logic [31:0] lit);
    logic [31:0] acc_a[2];
    logic [2:0]  acc_l[2];
    int n, off;
    bit faulted;
    logic [1:0] cpl;
    bit lock, rmw;
    cpl = 2'($urandom_range(0, 3));
    lock = 1'($urandom_range(0, 1));
    rmw = 1'($urandom_range(0, 1));
    n = 1; acc_a[0] = addr; acc_l[0] = len; acc_a[1] = '0; acc_l[1] = '0;
`ifdef MEMORY_READ_SPLIT_EN
    off = int'(addr[3:0]);
    if (off + int'(len) > 16) begin
      n = 2;
      acc_l[0] = 3'(16 - off);
      acc_a[1] = {addr[31:4], 4'h0} + 32'd16;
      acc_l[1] = 3'(int'(len) - (16 - off));
    end
`else
    off = 0;
`endif
    faulted = (fault_at >= 1 && fault_at <= n);
    if (!faulted && !mid_reset) exp_q.push_back(use_lit ? lit : bytes_le(addr, int'(len)));

    @(negedge clk);
    read_do = 1'b1; read_address = addr; read_length = len;
    read_cpl = cpl; read_lock = lock; read_rmw = rmw;
    #1;
    check("issue_do", tlbread_do, 1);
    check("issue_addr", tlbread_address, acc_a[0]);
    check("issue_len", tlbread_length, acc_l[0]);
    check("len_full", tlbread_length_full, len);
    check("cpl_lock_rmw", {tlbread_cpl, tlbread_lock, tlbread_rmw}, {cpl, lock, rmw});
    @(posedge clk); @(negedge clk);
    read_do = 1'b0;
    for (int k = 0; k < n; k++) begin
      int waits;
      waits = $urandom_range(0, 2);
      if (k == 0 && mid_reset && waits == 0) waits = 1;
      for (int w = 0; w < waits; w++) begin
        rd_reset = mid_reset && k == 0 && w == 0;
        #1;
        check("hold_do", tlbread_do, 1);
        check("hold_addr", tlbread_address, acc_a[k]);
        check("hold_len", tlbread_length, acc_l[k]);
        @(posedge clk); @(negedge clk);
        rd_reset = 1'b0;
      end
      if (k == fault_at - 1) begin
        tlbread_page_fault = fault_pf;
        tlbread_ac_fault = !fault_pf;
        tlbread_done = 1'($urandom_range(0, 1));
        tlbread_data = $urandom();
      end else begin
        tlbread_done = 1'b1;
        tlbread_data = bytes_le(acc_a[k], int'(acc_l[k]));
        if (n == 2 && k == 0) tlbread_data = tlbread_data | ($urandom() << (8 * int'(acc_l[k])));
      end
      #1;
      check("resp_do", tlbread_do, 1);
      check("resp_addr", tlbread_address, acc_a[k]);
      check("resp_len", tlbread_length, acc_l[k]);
      @(posedge clk); @(negedge clk);
      tlbread_done = 1'b0; tlbread_page_fault = 1'b0; tlbread_ac_fault = 1'b0; tlbread_data = '0;
      if (k == fault_at - 1) break;
    end
    if (faulted) begin
      #1;
      check("sticky_pf", read_page_fault, fault_pf);
      check("sticky_ac", read_ac_fault, !fault_pf);
      read_do = 1'b1;
      #1;
      check("blocked_do", tlbread_do, 0);
      @(posedge clk); @(negedge clk);
      #1;
      check("blocked_state", debug_state, 32'(RD_IDLE));
      check("still_sticky", {read_page_fault, read_ac_fault}, {fault_pf, !fault_pf});
      rd_reset = 1'b1;
      @(posedge clk); @(negedge clk);
      rd_reset = 1'b0; read_do = 1'b0;
      #1;
      check("sticky_cleared", {read_page_fault, read_ac_fault}, 0);
    end
  endtask

  initial begin
    logic [31:0] a;
    int fa;
    bit mr;
    // Reset values; faults follow the inputs only
    #3;
    check("rst_do", tlbread_do, 0);
    check("rst_done", read_done, 0);
    check("rst_state", debug_state, 32'(RD_IDLE));
    tlbread_page_fault = 1'b1;
    #1;
    check("rst_pf_follow", read_page_fault, 1);
    tlbread_page_fault = 1'b0;
    #1;
    check("rst_pf_low", read_page_fault, 0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    mem[32'h1004] = 8'h11; mem[32'h1005] = 8'h22; mem[32'h1006] = 8'h33; mem[32'h1007] = 8'h44;
    mem[32'h100E] = 8'hAA; mem[32'h100F] = 8'hBB; mem[32'h1010] = 8'hCC; mem[32'h1011] = 8'hDD;
    do_read(32'h0000_1004, 3'd4, 0, 1'b0, 1'b0, 1'b1, 32'h4433_2211);
    do_read(32'h0000_100E, 3'd4, 0, 1'b0, 1'b0, 1'b1, 32'hDDCC_BBAA);
    do_read(32'h0000_100F, 3'd2, 2, 1'b1, 1'b0, 1'b0, 32'd0);
    do_read(32'h0000_100F, 3'd2, 1, 1'b0, 1'b0, 1'b0, 32'd0);
    do_read(32'h0000_1004, 3'd4, 0, 1'b0, 1'b1, 1'b0, 32'd0);
    do_read(32'h0000_1004, 3'd4, 0, 1'b0, 1'b0, 1'b1, 32'h4433_2211);
    do_read(32'h0000_100E, 3'd4, 0, 1'b0, 1'b1, 1'b0, 32'd0);

    // rd_reset together with read_do in IDLE starts nothing
    @(negedge clk);
    read_do = 1'b1; rd_reset = 1'b1; read_address = 32'h2000; read_length = 3'd4;
    #1;
    check("rdreset_blocks_do", tlbread_do, 0);
    @(posedge clk); @(negedge clk);
    #1;
    check("rdreset_state", debug_state, 32'(RD_IDLE));
    read_do = 1'b0; rd_reset = 1'b0;

    for (int i = 0; i < 150; i++) begin
      a = $urandom();
      fa = ($urandom_range(0, 9) < 2) ? int'($urandom_range(1, 2)) : 0;
      mr = (fa == 0) && ($urandom_range(0, 7) == 0);
      do_read(a, 3'($urandom_range(1, 4)), fa, 1'($urandom_range(0, 1)), mr, 1'b0, 32'd0);
    end

    // Asynchronous reset in the middle of an access
    @(negedge clk);
    read_do = 1'b1; read_address = 32'h0000_100E; read_length = 3'd4;
    @(posedge clk); @(negedge clk);
    read_do = 1'b0;
`ifdef MEMORY_READ_SPLIT_EN
    tlbread_done = 1'b1; tlbread_data = bytes_le(32'h100E, 2);
    @(posedge clk); @(negedge clk);
    tlbread_done = 1'b0;
    #1;
    check("second_state", debug_state, 32'(RD_SECOND));
`endif
    #1; rst_n = 1'b0; #1;
    check("arst_do", tlbread_do, 0);
    check("arst_done", read_done, 0);
    check("arst_data", read_data, 0);
    check("arst_state", debug_state, 32'(RD_IDLE));
    @(negedge clk); rst_n = 1'b1;
    tlbread_done = 1'b1; tlbread_data = 32'hDEAD_BEEF;
    #1;
    check("post_rst_do", tlbread_do, 0);
    @(posedge clk); @(negedge clk);
    tlbread_done = 1'b0;
    repeat (3) @(negedge clk);
    #3;
    check("queue_drained", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/memory_read_split.md
MEMORY_READ_SPLIT -- requirements
Module: memory_read_split

Interface
REQ-001 SHALL have parameter LINE_LOG2, default 4, meaning log2 of the line size in bytes (line = 16 bytes).
REQ-002 SHALL have clk  in  1  single clock; all state on rising edge.
REQ-003 SHALL have rst_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have rd_reset  in  1  abort/flush of the current read step.
REQ-005 SHALL have read_do  in  1; read_done  out  1; read_page_fault  out  1; read_ac_fault  out  1.
REQ-006 SHALL have read_cpl  in  2; read_address  in  32; read_length  in  3 (legal 1..4); read_lock  in  1; read_rmw  in  1.
REQ-007 SHALL have read_data  out  32  merged little-endian result, byte 0 = lowest address.
REQ-008 SHALL have tlbread_do  out  1; tlbread_done  in  1; tlbread_page_fault  in  1; tlbread_ac_fault  in  1.
REQ-009 SHALL have tlbread_cpl  out  2; tlbread_address  out  32; tlbread_length  out  3; tlbread_length_full  out  3; tlbread_lock  out  1; tlbread_rmw  out  1; tlbread_data  in  32.

Function
REQ-010 SHALL drive tlbread_cpl, tlbread_length_full, tlbread_lock, tlbread_rmw directly from read_cpl, read_length, read_lock, read_rmw.
REQ-011 SHALL compute left = 16 - read_address[3:0] (5 bits); length_1 = min(read_length, left); length_2 = read_length - length_1; address_2 = {read_address[31:4],4'h0} + 16.
REQ-012 SHALL implement states IDLE, FIRST_WAIT, SECOND (2-bit encoding).
REQ-013 IDLE: when read_do and not rd_reset and not read_page_fault and not read_ac_fault, SHALL assert tlbread_do combinationally with address=read_address, length=length_1, capture length_2/address_2, and go to FIRST_WAIT.
REQ-014 FIRST_WAIT: SHALL hold tlbread_do with address=read_address, length=length_1 until response.
REQ-015 FIRST_WAIT: on tlbread_page_fault or tlbread_ac_fault SHALL go to IDLE without read_done.
REQ-016 FIRST_WAIT: on tlbread_done with captured length_2 != 0, SHALL register the low length_1 bytes of tlbread_data into a 24-bit buffer and go to SECOND.
REQ-017 FIRST_WAIT: on tlbread_done with length_2 == 0, SHALL pulse read_done for that cycle (suppressed if reset_waiting) with read_data = tlbread_data, and go to IDLE.
REQ-018 SECOND: SHALL hold tlbread_do with address=captured address_2, length=captured length_2; on done, SHALL pulse read_done (unless reset_waiting) with read_data = buffer | (tlbread_data << 8*length_1), truncated to 32 bits; on done or fault go to IDLE.
REQ-019 read_data SHALL be 0 in every cycle read_done is low.
REQ-020 read_page_fault/read_ac_fault SHALL equal the tlbread fault input OR a sticky flag; sticky flag sets when the fault input is high and reset_waiting is low, clears on rd_reset.
REQ-021 reset_waiting SHALL set when rd_reset is high outside IDLE, clear in IDLE; the outstanding TLB access SHALL still complete, silently.
REQ-022 rd_reset and read_do in the same IDLE cycle: no access SHALL start.
REQ-023 Fault and done in the same cycle: fault SHALL win, no read_done.

Reset
REQ-024 On rst_n low, state=IDLE, buffer=0, captured length/address=0, reset_waiting=0, sticky faults=0; hence tlbread_do=0, read_done=0, read_data=0, faults follow inputs only.
REQ-025 Reset asserted mid-access SHALL abandon the access immediately; no read_done after release.

Configuration
REQ-026 Macro MEMORY_READ_SPLIT_EN: defined, line-crossing reads split per REQ-011; undefined, length_1 = read_length, length_2 = 0, SECOND unreachable, buffer removed.

Structure
REQ-027 State encodings and LINE_LOG2 default SHALL live in shared package memory_pkg, alongside the write-side constants.
REQ-028 One sub-module memory_read_merge (combinational byte buffer/shift/OR) is natural; FSM stays in top.

Verification
REQ-029 addr 0x00001004 len 4, done with data 0x44332211 -> one access, tlbread_length 4, read_done one cycle, read_data 0x44332211.
REQ-030 addr 0x0000100E len 4 (SPLIT_EN), data1 0x0000BBAA, data2 0x0000DDCC -> accesses at 0x100E len 2, 0x1010 len 2; read_data 0xDDCCBBAA.
REQ-031 Same as 030 without macro -> single access 0x100E len 4, read_data = data1.
REQ-032 addr 0x0000100F len 2, page fault on second access -> read_page_fault stays high, no read_done, new read_do ignored until rd_reset.
REQ-033 rd_reset during FIRST_WAIT, later done -> no read_done, state returns IDLE, next read_do accepted.
REQ-034 rst_n low during SECOND -> tlbread_do=0 asynchronously, all outputs at reset values.
